// File: rtl/dpll_assign_trail.sv
// dpll_assign_trail: DPLL assignment trail with chronological backtracking and decision flipping.
// Optional DPLL_TRAIL_STATS_EN adds saturating dec_count/bt_count outputs.
module dpll_assign_trail #(
    parameter int WIDTH = 4,
    parameter int N     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             pick_ena,
    input  logic             dec_valid,
    input  logic [WIDTH-1:0] dec_var,
    input  logic             imp_valid,
    input  logic [WIDTH-1:0] imp_var,
    input  logic             imp_val,
    input  logic             conflict,
    input  logic             prop_done,
    output logic [N-1:0]     lit_assigned,
    output logic [N-1:0]     lit_value,
    output logic [WIDTH:0]   trail_level,
    output logic             busy,
    output logic             sat,
    output logic             unsat
`ifdef DPLL_TRAIL_STATS_EN
    ,
    output logic [15:0]      dec_count,
    output logic [15:0]      bt_count
`endif
);
    localparam int LW = WIDTH + 1;

    typedef enum logic [2:0] {IDLE, REQ, PROP, BT, SAT, UNSAT} state_t;
    state_t state, nxt;

    logic [WIDTH-1:0] t_var [N];
    logic             t_val [N];
    logic             t_dec [N];
    logic             t_flp [N];

    logic [WIDTH-1:0] top, push_var;
    logic             all_set, dec_acc, imp_acc, flip, pop, push, push_val;

    always_comb begin
        top      = WIDTH'(trail_level - LW'(1));
        all_set  = &lit_assigned;
        dec_acc  = state == REQ && !start && !all_set && dec_valid && !lit_assigned[dec_var];
        imp_acc  = state == PROP && !start && !conflict && !prop_done && imp_valid && !lit_assigned[imp_var];
        flip     = state == BT && !start && trail_level != '0 && t_dec[top] && !t_flp[top];
        pop      = state == BT && !start && trail_level != '0 && !flip;
        push     = dec_acc || imp_acc;
        push_var = dec_acc ? dec_var : imp_var;
        push_val = dec_acc ? 1'b0 : imp_val;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= nxt;

    always_comb begin
        nxt = state;
        if (start)
            nxt = REQ;
        else
            case (state)
                REQ:     nxt = all_set ? SAT : dec_acc ? PROP : REQ;
                PROP:    nxt = conflict ? BT : prop_done ? (all_set ? SAT : REQ) : PROP;
                BT:      nxt = trail_level == '0 ? UNSAT : flip ? PROP : BT;
                default: nxt = state;
            endcase
    end

    always_comb begin
        pick_ena = state == REQ;
        busy     = state == REQ || state == PROP || state == BT;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            lit_assigned <= '0;
            lit_value    <= '0;
            trail_level  <= '0;
            sat          <= 1'b0;
            unsat        <= 1'b0;
        end else if (start) begin
            lit_assigned <= '0;
            lit_value    <= '0;
            trail_level  <= '0;
            sat          <= 1'b0;
            unsat        <= 1'b0;
        end else begin
            if (push) begin
                lit_assigned[push_var] <= 1'b1;
                lit_value[push_var]    <= push_val;
                trail_level            <= trail_level + LW'(1);
            end
            if (flip)
                lit_value[t_var[top]] <= ~t_val[top];
            if (pop) begin
                lit_assigned[t_var[top]] <= 1'b0;
                lit_value[t_var[top]]    <= 1'b0;
                trail_level              <= trail_level - LW'(1);
            end
            sat   <= sat | (nxt == SAT);
            unsat <= unsat | (nxt == UNSAT);
        end

    // Entry contents need no reset: only slots below trail_level are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            t_var[trail_level[WIDTH-1:0]] <= push_var;
            t_val[trail_level[WIDTH-1:0]] <= push_val;
            t_dec[trail_level[WIDTH-1:0]] <= dec_acc;
            t_flp[trail_level[WIDTH-1:0]] <= 1'b0;
        end
        if (flip) begin
            t_val[top] <= ~t_val[top];
            t_flp[top] <= 1'b1;
        end
    end

`ifdef DPLL_TRAIL_STATS_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            dec_count <= '0;
            bt_count  <= '0;
        end else if (start) begin
            dec_count <= '0;
            bt_count  <= '0;
        end else begin
            dec_count <= dec_acc && dec_count != 16'hFFFF ? dec_count + 16'd1 : dec_count;
            bt_count  <= flip && bt_count != 16'hFFFF ? bt_count + 16'd1 : bt_count;
        end
`endif
endmodule

// File: tb/tb_dpll_assign_trail.sv
// tb_dpll_assign_trail: directed checks of dpll_assign_trail (reset, decisions, backtrack, UNSAT, SAT).
module tb_dpll_assign_trail;
    logic        clk, rst, start, pick_ena, dec_valid, imp_valid, imp_val, conflict, prop_done;
    logic [3:0]  dec_var, imp_var;
    logic [15:0] lit_assigned, lit_value;
    logic [4:0]  trail_level;
    logic        busy, sat, unsat;
`ifdef DPLL_TRAIL_STATS_EN
    logic [15:0] dec_count, bt_count;
`endif
    int checks = 0;
    int failures = 0;
    logic [15:0] exp_la, exp_lv;
    logic [4:0]  exp_tl;
    logic [3:0]  v;

    dpll_assign_trail dut (
        .clk(clk), .rst(rst), .start(start), .pick_ena(pick_ena),
        .dec_valid(dec_valid), .dec_var(dec_var),
        .imp_valid(imp_valid), .imp_var(imp_var), .imp_val(imp_val),
        .conflict(conflict), .prop_done(prop_done),
        .lit_assigned(lit_assigned), .lit_value(lit_value), .trail_level(trail_level),
        .busy(busy), .sat(sat), .unsat(unsat)
`ifdef DPLL_TRAIL_STATS_EN
        , .dec_count(dec_count), .bt_count(bt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all0(input string tag);
        chk({tag, "_pick"}, 32'(pick_ena), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sat"}, 32'(sat), 32'd0);
        chk({tag, "_unsat"}, 32'(unsat), 32'd0);
        chk({tag, "_la"}, 32'(lit_assigned), 32'd0);
        chk({tag, "_lv"}, 32'(lit_value), 32'd0);
        chk({tag, "_tl"}, 32'(trail_level), 32'd0);
    endtask

    task automatic build_5_2_7();
        start = 1'b1; tick(); start = 1'b0;
        dec_valid = 1'b1; dec_var = 4'd5; tick(); dec_valid = 1'b0;
        imp_valid = 1'b1; imp_var = 4'd2; imp_val = 1'b1; tick();
        imp_var = 4'd7; imp_val = 1'b0; tick(); imp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dec_valid = 1'b0; dec_var = '0;
        imp_valid = 1'b0; imp_var = '0; imp_val = 1'b0; conflict = 1'b0; prop_done = 1'b0;
        #3 rst = 1'b0;
        #1 chk_all0("reset");
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        tick();
        chk("idle_pick", 32'(pick_ena), 32'd0);

        // Start, decision, implications, prop_done
        start = 1'b1; tick(); start = 1'b0;
        chk("start_pick", 32'(pick_ena), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        dec_valid = 1'b1; dec_var = 4'd5; tick(); dec_valid = 1'b0;
        chk("dec5_la", 32'(lit_assigned), 32'h0020);
        chk("dec5_tl", 32'(trail_level), 32'd1);
        chk("dec5_pick", 32'(pick_ena), 32'd0);
        imp_valid = 1'b1; imp_var = 4'd2; imp_val = 1'b1; tick();
        chk("imp2_la", 32'(lit_assigned), 32'h0024);
        imp_var = 4'd7; imp_val = 1'b0; tick();
        chk("imp7_la", 32'(lit_assigned), 32'h00A4);
        chk("imp7_lv", 32'(lit_value), 32'h0004);
        chk("imp7_tl", 32'(trail_level), 32'd3);
        imp_var = 4'd5; imp_val = 1'b1; tick(); imp_valid = 1'b0;
        chk("imp_dup_tl", 32'(trail_level), 32'd3);
        chk("imp_dup_lv", 32'(lit_value), 32'h0004);
        prop_done = 1'b1; tick(); prop_done = 1'b0;
        chk("pdone_pick", 32'(pick_ena), 32'd1);
        chk("pdone_tl", 32'(trail_level), 32'd3);
        conflict = 1'b1; tick(); conflict = 1'b0;
        chk("req_conf_ign_pick", 32'(pick_ena), 32'd1);
        chk("req_conf_ign_tl", 32'(trail_level), 32'd3);

        // Conflict flip: pop 7, pop 2, flip 5
        build_5_2_7();
        chk("cf_pre_tl", 32'(trail_level), 32'd3);
        conflict = 1'b1; tick(); conflict = 1'b0;
        chk("cf_bt_tl", 32'(trail_level), 32'd3);
        tick();
        chk("cf_pop7_tl", 32'(trail_level), 32'd2);
        chk("cf_pop7_la", 32'(lit_assigned), 32'h0024);
        tick();
        chk("cf_pop2_tl", 32'(trail_level), 32'd1);
        chk("cf_pop2_la", 32'(lit_assigned), 32'h0020);
        chk("cf_pop2_lv", 32'(lit_value), 32'h0000);
        tick();
        chk("cf_flip_lv", 32'(lit_value), 32'h0020);
        chk("cf_flip_la", 32'(lit_assigned), 32'h0020);
        chk("cf_flip_tl", 32'(trail_level), 32'd1);
        chk("cf_flip_busy", 32'(busy), 32'd1);
`ifdef DPLL_TRAIL_STATS_EN
        chk("stats_dec", 32'(dec_count), 32'd1);
        chk("stats_bt", 32'(bt_count), 32'd1);
`endif

        // UNSAT
        start = 1'b1; tick(); start = 1'b0;
        dec_valid = 1'b1; dec_var = 4'd0; tick(); dec_valid = 1'b0;
        conflict = 1'b1; tick(); conflict = 1'b0;
        tick();
        chk("un_flip_lv", 32'(lit_value), 32'h0001);
        conflict = 1'b1; tick(); conflict = 1'b0;
        tick();
        chk("un_pop_tl", 32'(trail_level), 32'd0);
        tick();
        chk("un_unsat", 32'(unsat), 32'd1);
        chk("un_tl", 32'(trail_level), 32'd0);
        chk("un_la", 32'(lit_assigned), 32'h0000);
        chk("un_busy", 32'(busy), 32'd0);
        tick();
        chk("un_hold", 32'(unsat), 32'd1);

        // SAT run with a repeat decision and a conflict coinciding with an implication
        start = 1'b1; tick(); start = 1'b0;
        chk("sat_start_unsat", 32'(unsat), 32'd0);
        exp_la = '0; exp_lv = '0; exp_tl = '0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i * 7);
            if (i == 3) begin
                dec_valid = 1'b1; dec_var = 4'd0; tick(); dec_valid = 1'b0;
                chk("rep_dec_tl", 32'(trail_level), 32'(exp_tl));
                chk("rep_dec_pick", 32'(pick_ena), 32'd1);
            end
            dec_valid = 1'b1; dec_var = v; tick(); dec_valid = 1'b0;
            exp_la[v] = 1'b1; exp_tl++;
            chk("sat_dec_la", 32'(lit_assigned), 32'(exp_la));
            if (i == 5) begin
                conflict = 1'b1; imp_valid = 1'b1; imp_var = 4'd10; imp_val = 1'b1; tick();
                conflict = 1'b0; imp_valid = 1'b0;
                chk("coinc_imp_dropped", 32'(lit_assigned), 32'(exp_la));
                tick();
                exp_lv[v] = 1'b1;
                chk("coinc_flip_lv", 32'(lit_value), 32'(exp_lv));
                chk("coinc_flip_tl", 32'(trail_level), 32'(exp_tl));
            end
            prop_done = 1'b1; tick(); prop_done = 1'b0;
            if (i < 15) chk("sat_step_pick", 32'(pick_ena), 32'd1);
        end
        chk("sat_sat", 32'(sat), 32'd1);
        chk("sat_la", 32'(lit_assigned), 32'hFFFF);
        chk("sat_lv", 32'(lit_value), 32'(exp_lv));
        chk("sat_tl", 32'(trail_level), 32'd16);
        chk("sat_busy", 32'(busy), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_sat", 32'(sat), 32'd0);
        chk("restart_la", 32'(lit_assigned), 32'h0000);

        // Asynchronous reset in the middle of a backtrack
        build_5_2_7();
        conflict = 1'b1; tick(); conflict = 1'b0;
        tick();
        chk("mid_bt_tl", 32'(trail_level), 32'd2);
        #2 rst = 1'b0;
        #1 chk_all0("async_rst");
        tick(); rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
